// File: rtl/rs232_pkg.sv
// rs232_pkg: shared FSM states, oversampling constants and 12 MHz baud increments for rs232_rcv/rs232_xmit.
package rs232_pkg;
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} rs232_state_t;
  localparam int OSR = 16;
  localparam int SAMPLE_MID = 8;
  localparam int DATA_BITS = 8;
  // Increments for a 16-bit accumulator: 12e6 * inc / 2^16 ~= 16 x baud
  localparam int BAUD_INC_115200 = 10066;
  localparam int BAUD_INC_57600 = 5033;
  localparam int BAUD_INC_9600 = 839;
endpackage

// File: rtl/rs232_rcv_if.sv
// rs232_rcv_if: byte handshake and sticky error flags between rs232_rcv (slave) and its consumer (master).
// parity_err_o exists only when RS232_RCV_PARITY_EN is defined.
interface rs232_rcv_if;
  logic [7:0] data_o;
  logic data_avail_o;
  logic read_ack_i;
  logic framing_err_o;
  logic overrun_err_o;
  logic err_clr_i;
  logic busy_o;
`ifdef RS232_RCV_PARITY_EN
  logic parity_err_o;
`endif
  modport slave (
    output data_o, data_avail_o, framing_err_o, overrun_err_o, busy_o,
`ifdef RS232_RCV_PARITY_EN
    output parity_err_o,
`endif
    input read_ack_i, err_clr_i
  );
  modport master (
    input data_o, data_avail_o, framing_err_o, overrun_err_o, busy_o,
`ifdef RS232_RCV_PARITY_EN
    input parity_err_o,
`endif
    output read_ack_i, err_clr_i
  );
endinterface

// File: rtl/rs232_baud_tick.sv
// rs232_baud_tick: free-running phase accumulator; tick_o is the one-clock carry out at 16x baud.
module rs232_baud_tick
  import rs232_pkg::*;
#(
  parameter int ACC_WIDTH = 16,
  parameter int BAUD_INC = BAUD_INC_115200
) (
  input  logic clk_i,
  input  logic reset_n_i,
  output logic tick_o
);
  logic [ACC_WIDTH:0] acc;
  always_ff @(posedge clk_i or negedge reset_n_i)
    if (!reset_n_i) acc <= '0;
    else acc <= {1'b0, acc[ACC_WIDTH-1:0]} + (ACC_WIDTH+1)'(BAUD_INC);
  assign tick_o = acc[ACC_WIDTH];
endmodule

// File: rtl/rs232_rcv.sv
// rs232_rcv: 16x-oversampled 8N1 receiver with one-byte holding register and sticky framing/overrun flags.
// Define RS232_RCV_PARITY_EN for 8E1 frames with a sticky parity_err_o.
module rs232_rcv
  import rs232_pkg::*;
#(
  parameter int ACC_WIDTH = 16,
  parameter int BAUD_INC = BAUD_INC_115200,
  parameter int VOTE_LO = 7
) (
  input logic clk_i,
  input logic reset_n_i,
  input logic rx_i,
  rs232_rcv_if.slave bus
);
`ifdef RS232_RCV_PARITY_EN
  localparam rs232_state_t AFTER_DATA = PARITY;
`else
  localparam rs232_state_t AFTER_DATA = STOP;
`endif
  localparam logic [3:0] S_V0 = 4'(VOTE_LO);
  localparam logic [3:0] S_V1 = 4'(VOTE_LO + 1);
  localparam logic [3:0] S_V2 = 4'(VOTE_LO + 2);
  localparam logic [3:0] S_MID = 4'(SAMPLE_MID);
  localparam logic [3:0] S_END = 4'(OSR - 1);
  logic tick;
  logic [2:0] sync;
  logic rx_s, fall, maj, deliver, ferr_set;
  logic t_v0, t_v1, t_v2, t_mid, t_end;
  rs232_state_t state, state_n;
  logic [3:0] cnt, cnt_n;
  logic [2:0] bidx, bidx_n;
  logic [7:0] shift, shift_n;
  logic [1:0] vote, vote_n;
`ifdef RS232_RCV_PARITY_EN
  logic perr_set;
`endif
  rs232_baud_tick #(.ACC_WIDTH(ACC_WIDTH), .BAUD_INC(BAUD_INC)) u_baud_tick (
    .clk_i(clk_i),
    .reset_n_i(reset_n_i),
    .tick_o(tick)
  );
  // sync[1] is the synchronized line; sync[2] is its previous value for edge detect
  assign rx_s = sync[1];
  assign fall = sync[2] & ~sync[1];
  assign t_v0 = tick && cnt == S_V0;
  assign t_v1 = tick && cnt == S_V1;
  assign t_v2 = tick && cnt == S_V2;
  assign t_mid = tick && cnt == S_MID;
  assign t_end = tick && cnt == S_END;
  assign maj = (vote[0] & vote[1]) | (rx_s & (vote[0] | vote[1]));
  assign bus.busy_o = state != IDLE;
  always_comb begin
    state_n = state;
    cnt_n = tick ? cnt + 4'd1 : cnt;
    bidx_n = bidx;
    shift_n = shift;
    vote_n = {t_v1 ? rx_s : vote[1], t_v0 ? rx_s : vote[0]};
    deliver = 1'b0;
    ferr_set = 1'b0;
`ifdef RS232_RCV_PARITY_EN
    perr_set = 1'b0;
`endif
    case (state)
      IDLE: if (fall) begin
        state_n = START;
        cnt_n = '0;
      end
      START: if (t_mid && rx_s) state_n = IDLE;
        else if (t_end) begin
          state_n = DATA;
          bidx_n = '0;
        end
      DATA: begin
        if (t_v2) shift_n = {maj, shift[7:1]};
        if (t_end) begin
          bidx_n = bidx + 3'd1;
          state_n = bidx == 3'(DATA_BITS - 1) ? AFTER_DATA : DATA;
        end
      end
`ifdef RS232_RCV_PARITY_EN
      PARITY: begin
        if (t_v2) perr_set = ^{shift, maj};
        if (t_end) state_n = STOP;
      end
`endif
      // Leave at sample 9 so a back-to-back start edge is caught early
      STOP: if (t_v2) begin
        deliver = 1'b1;
        ferr_set = ~maj;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk_i or negedge reset_n_i)
    if (!reset_n_i) begin
      sync <= '1;
      state <= IDLE;
      cnt <= '0;
      bidx <= '0;
      shift <= '0;
      vote <= '0;
    end else begin
      sync <= {sync[1:0], rx_i};
      state <= state_n;
      cnt <= cnt_n;
      bidx <= bidx_n;
      shift <= shift_n;
      vote <= vote_n;
    end
  // A delivery on the same clock as read_ack_i wins and is not an overrun
  always_ff @(posedge clk_i or negedge reset_n_i)
    if (!reset_n_i) begin
      bus.data_o <= '0;
      bus.data_avail_o <= 1'b0;
      bus.framing_err_o <= 1'b0;
      bus.overrun_err_o <= 1'b0;
    end else begin
      if (deliver) bus.data_o <= shift;
      bus.data_avail_o <= deliver | (bus.data_avail_o & ~bus.read_ack_i);
      bus.framing_err_o <= ferr_set | (bus.framing_err_o & ~bus.err_clr_i);
      bus.overrun_err_o <= (deliver & bus.data_avail_o & ~bus.read_ack_i) | (bus.overrun_err_o & ~bus.err_clr_i);
    end
`ifdef RS232_RCV_PARITY_EN
  always_ff @(posedge clk_i or negedge reset_n_i)
    if (!reset_n_i) bus.parity_err_o <= 1'b0;
    else bus.parity_err_o <= perr_set | (bus.parity_err_o & ~bus.err_clr_i);
`endif
endmodule

// File: tb/tb_rs232_rcv.sv
// tb_rs232_rcv: drives real-time-based serial frames into rs232_rcv and checks delivered bytes against a queue.
`timescale 1ns/1ps
module tb_rs232_rcv;
  localparam real BIT_NS = 1.0e9 / 115200.0;
`ifdef RS232_RCV_PARITY_EN
  localparam real FRAME_BITS = 10.0;
  logic par_flip = 1'b0;
`else
  localparam real FRAME_BITS = 9.0;
`endif
  typedef struct packed {logic [7:0] d; logic fe; logic oe;} exp_t;
  logic FX2_CLK = 1'b0;
  logic reset_n = 1'b0;
  logic rx = 1'b1;
  int errors = 0;
  int checks = 0;
  exp_t sb[$];
  rs232_rcv_if bus();
  rs232_rcv dut (.clk_i(FX2_CLK), .reset_n_i(reset_n), .rx_i(rx), .bus(bus));
  always #41.667 FX2_CLK = ~FX2_CLK;
  task automatic send_byte(input logic [7:0] b, input logic stop_bit, input real scale);
    real bt;
    bt = BIT_NS * scale;
    rx = 1'b0;
    #(bt);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      #(bt);
    end
`ifdef RS232_RCV_PARITY_EN
    rx = ^b ^ par_flip;
    #(bt);
`endif
    rx = stop_bit;
    #(bt);
    rx = 1'b1;
  endtask
  task automatic wait_avail(input int max_clk, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < max_clk && !ok; i++) begin
      @(negedge FX2_CLK);
      ok = bus.data_avail_o;
    end
  endtask
  task automatic pulse_ack;
    @(negedge FX2_CLK) bus.read_ack_i = 1'b1;
    @(negedge FX2_CLK) bus.read_ack_i = 1'b0;
  endtask
  task automatic pulse_clr;
    @(negedge FX2_CLK) bus.err_clr_i = 1'b1;
    @(negedge FX2_CLK) bus.err_clr_i = 1'b0;
  endtask
  task automatic test_reset;
    repeat (3) @(negedge FX2_CLK);
    checks++; if (bus.data_o !== 8'h00) begin errors++; $display("FAIL reset_data got=%h want=00", bus.data_o); end
    checks++; if (bus.data_avail_o !== 1'b0) begin errors++; $display("FAIL reset_avail got=%b want=0", bus.data_avail_o); end
    checks++; if (bus.framing_err_o !== 1'b0 || bus.overrun_err_o !== 1'b0) begin errors++; $display("FAIL reset_err got=%b%b want=00", bus.framing_err_o, bus.overrun_err_o); end
    checks++; if (bus.busy_o !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b want=0", bus.busy_o); end
    @(negedge FX2_CLK) reset_n = 1'b1;
    repeat (20) @(negedge FX2_CLK);
  endtask
  task automatic test_basic;
    exp_t e;
    bit ok;
    real t0, el;
    sb.push_back('{8'h55, 1'b0, 1'b0});
    t0 = $realtime;
    fork
      send_byte(8'h55, 1'b1, 1.0);
      begin
        #(BIT_NS * (FRAME_BITS - 0.7));
        @(negedge FX2_CLK);
        checks++; if (bus.data_avail_o !== 1'b0) begin errors++; $display("FAIL basic_early got=%b want=0", bus.data_avail_o); end
        wait_avail(300, ok);
        el = ($realtime - t0) / BIT_NS;
      end
    join
    checks++; if (!ok) begin errors++; $display("FAIL basic_timeout got=0 want=1"); end
    checks++; if (el < FRAME_BITS + 0.4 || el > FRAME_BITS + 0.8) begin errors++; $display("FAIL basic_latency got=%f bits want=%f", el, FRAME_BITS + 0.5); end
    e = sb.pop_front();
    checks++; if (bus.data_o !== e.d) begin errors++; $display("FAIL basic_data got=%h want=%h", bus.data_o, e.d); end
    checks++; if ({bus.framing_err_o, bus.overrun_err_o} !== {e.fe, e.oe}) begin errors++; $display("FAIL basic_err got=%b%b want=%b%b", bus.framing_err_o, bus.overrun_err_o, e.fe, e.oe); end
    pulse_ack();
    checks++; if (bus.data_avail_o !== 1'b0) begin errors++; $display("FAIL basic_ack got=%b want=0", bus.data_avail_o); end
  endtask
  task automatic test_back_to_back;
    exp_t e;
    bit ok;
    sb.push_back('{8'hA3, 1'b0, 1'b0});
    sb.push_back('{8'h0F, 1'b0, 1'b0});
    fork
      begin
        send_byte(8'hA3, 1'b1, 1.0);
        send_byte(8'h0F, 1'b1, 1.0);
      end
      for (int k = 0; k < 2; k++) begin
        wait_avail(1300, ok);
        checks++; if (!ok) begin errors++; $display("FAIL b2b_timeout byte=%0d got=0 want=1", k); end
        checks++; if (bus.busy_o !== 1'b0) begin errors++; $display("FAIL b2b_busy byte=%0d got=%b want=0", k, bus.busy_o); end
        e = sb.pop_front();
        checks++; if (bus.data_o !== e.d) begin errors++; $display("FAIL b2b_data byte=%0d got=%h want=%h", k, bus.data_o, e.d); end
        checks++; if ({bus.framing_err_o, bus.overrun_err_o} !== {e.fe, e.oe}) begin errors++; $display("FAIL b2b_err byte=%0d got=%b%b want=%b%b", k, bus.framing_err_o, bus.overrun_err_o, e.fe, e.oe); end
        pulse_ack();
      end
    join
  endtask
  task automatic test_overrun;
    exp_t e;
    bit ok;
    sb.push_back('{8'h11, 1'b0, 1'b0});
    fork
      send_byte(8'h11, 1'b1, 1.0);
      wait_avail(1300, ok);
    join
    e = sb.pop_front();
    checks++; if (!ok || bus.data_o !== e.d) begin errors++; $display("FAIL ovr_first got=%h want=%h", bus.data_o, e.d); end
    sb.push_back('{8'h22, 1'b0, 1'b1});
    send_byte(8'h22, 1'b1, 1.0);
    @(negedge FX2_CLK);
    e = sb.pop_front();
    checks++; if (bus.data_o !== e.d) begin errors++; $display("FAIL ovr_data got=%h want=%h", bus.data_o, e.d); end
    checks++; if ({bus.framing_err_o, bus.overrun_err_o} !== {e.fe, e.oe}) begin errors++; $display("FAIL ovr_err got=%b%b want=%b%b", bus.framing_err_o, bus.overrun_err_o, e.fe, e.oe); end
    pulse_clr();
    checks++; if (bus.overrun_err_o !== 1'b0) begin errors++; $display("FAIL ovr_clr got=%b want=0", bus.overrun_err_o); end
    checks++; if (bus.data_avail_o !== 1'b1) begin errors++; $display("FAIL ovr_avail got=%b want=1", bus.data_avail_o); end
    pulse_ack();
  endtask
  task automatic test_framing;
    exp_t e;
    bit ok;
    sb.push_back('{8'h7E, 1'b1, 1'b0});
    fork
      send_byte(8'h7E, 1'b0, 1.0);
      wait_avail(1300, ok);
    join
    e = sb.pop_front();
    checks++; if (!ok || bus.data_o !== e.d) begin errors++; $display("FAIL frm_data got=%h want=%h", bus.data_o, e.d); end
    checks++; if ({bus.framing_err_o, bus.overrun_err_o} !== {e.fe, e.oe}) begin errors++; $display("FAIL frm_err got=%b%b want=%b%b", bus.framing_err_o, bus.overrun_err_o, e.fe, e.oe); end
    pulse_ack();
    pulse_clr();
    checks++; if (bus.framing_err_o !== 1'b0) begin errors++; $display("FAIL frm_clr got=%b want=0", bus.framing_err_o); end
    #(BIT_NS * 2.0);
    sb.push_back('{8'h41, 1'b0, 1'b0});
    fork
      send_byte(8'h41, 1'b1, 1.0);
      wait_avail(1300, ok);
    join
    e = sb.pop_front();
    checks++; if (!ok || bus.data_o !== e.d) begin errors++; $display("FAIL frm_next got=%h want=%h", bus.data_o, e.d); end
    checks++; if (bus.framing_err_o !== e.fe) begin errors++; $display("FAIL frm_next_err got=%b want=%b", bus.framing_err_o, e.fe); end
    pulse_ack();
  endtask
  task automatic test_glitch;
    @(negedge FX2_CLK) rx = 1'b0;
    repeat (3) @(negedge FX2_CLK);
    rx = 1'b1;
    repeat (20) @(negedge FX2_CLK);
    checks++; if (bus.busy_o !== 1'b1) begin errors++; $display("FAIL glitch_seen got=%b want=1", bus.busy_o); end
    repeat (84) @(negedge FX2_CLK);
    checks++; if (bus.busy_o !== 1'b0) begin errors++; $display("FAIL glitch_idle got=%b want=0", bus.busy_o); end
    checks++; if (bus.data_avail_o !== 1'b0) begin errors++; $display("FAIL glitch_avail got=%b want=0", bus.data_avail_o); end
  endtask
  task automatic test_skew;
    exp_t e;
    bit ok;
    real sc[2] = '{1.03, 0.97};
    for (int k = 0; k < 2; k++) begin
      sb.push_back('{8'hC5, 1'b0, 1'b0});
      fork
        send_byte(8'hC5, 1'b1, sc[k]);
        wait_avail(1400, ok);
      join
      e = sb.pop_front();
      checks++; if (!ok || bus.data_o !== e.d) begin errors++; $display("FAIL skew_data scale=%f got=%h want=%h", sc[k], bus.data_o, e.d); end
      checks++; if ({bus.framing_err_o, bus.overrun_err_o} !== {e.fe, e.oe}) begin errors++; $display("FAIL skew_err scale=%f got=%b%b want=%b%b", sc[k], bus.framing_err_o, bus.overrun_err_o, e.fe, e.oe); end
      pulse_ack();
    end
  endtask
  task automatic test_reset_mid;
    fork
      send_byte(8'hFE, 1'b1, 1.0);
      begin
        #(BIT_NS * 4.5);
        reset_n = 1'b0;
        @(negedge FX2_CLK);
        checks++; if (bus.busy_o !== 1'b0 || bus.data_avail_o !== 1'b0 || bus.data_o !== 8'h00) begin errors++; $display("FAIL rstmid_abort got=%b%b%h want=0000", bus.busy_o, bus.data_avail_o, bus.data_o); end
        repeat (2) @(negedge FX2_CLK);
        reset_n = 1'b1;
      end
    join
    repeat (300) @(negedge FX2_CLK);
    checks++; if (bus.data_avail_o !== 1'b0 || bus.busy_o !== 1'b0) begin errors++; $display("FAIL rstmid_after got=%b%b want=00", bus.data_avail_o, bus.busy_o); end
  endtask
  task automatic test_break;
    exp_t e;
    bit ok;
    sb.push_back('{8'h00, 1'b1, 1'b0});
    @(negedge FX2_CLK) rx = 1'b0;
    wait_avail(1300, ok);
    e = sb.pop_front();
    checks++; if (!ok || bus.data_o !== e.d) begin errors++; $display("FAIL brk_data got=%h want=%h", bus.data_o, e.d); end
    checks++; if (bus.framing_err_o !== e.fe) begin errors++; $display("FAIL brk_ferr got=%b want=%b", bus.framing_err_o, e.fe); end
    pulse_ack();
    repeat (2000) @(negedge FX2_CLK);
    checks++; if (bus.busy_o !== 1'b0 || bus.data_avail_o !== 1'b0) begin errors++; $display("FAIL brk_repeat got=%b%b want=00", bus.busy_o, bus.data_avail_o); end
    rx = 1'b1;
    pulse_clr();
    checks++; if (bus.framing_err_o !== 1'b0) begin errors++; $display("FAIL brk_clr got=%b want=0", bus.framing_err_o); end
    repeat (50) @(negedge FX2_CLK);
  endtask
`ifdef RS232_RCV_PARITY_EN
  task automatic test_parity;
    bit ok;
    logic [1:0] flips = 2'b01;
    for (int k = 0; k < 2; k++) begin
      par_flip = flips[k];
      fork
        send_byte(8'h03, 1'b1, 1.0);
        wait_avail(1400, ok);
      join
      checks++; if (!ok || bus.data_o !== 8'h03) begin errors++; $display("FAIL par_data flip=%b got=%h want=03", par_flip, bus.data_o); end
      checks++; if (bus.parity_err_o !== par_flip) begin errors++; $display("FAIL par_err flip=%b got=%b want=%b", par_flip, bus.parity_err_o, par_flip); end
      pulse_ack();
      pulse_clr();
    end
    par_flip = 1'b0;
  endtask
`endif
  initial begin
    #(BIT_NS * 400.0);
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end
  initial begin
    bus.read_ack_i = 1'b0;
    bus.err_clr_i = 1'b0;
    test_reset();
    test_basic();
    test_back_to_back();
    test_overrun();
    test_framing();
    test_glitch();
    test_skew();
    test_reset_mid();
    test_break();
`ifdef RS232_RCV_PARITY_EN
    test_parity();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
